qslave_seq: RTL and testbench
=============================

Name: qslave_seq

Overview:
- Parametrised QBUS slave-cycle sequencer serving NCHAN register devices on one Am2908 transceiver bank.
- Synchronises RDIN/RDOUT and the per-device match/vector requests into clk20.
- Arbitrates by fixed priority and drives TRPLY plus the Am2908 controls DALtx/DALbe/DALst with a programmable settle delay.
- Muxes the selected device's read data onto TDAL and issues one-clock write strobes. It replaces the hand-coded per-device slave logic in the top level.

Parameters:
- NCHAN, 4, number of device channels (1..8); channel 0 has highest priority.
- SETTLE, 2, clk20 cycles from DALtx assertion to DALbe/DALst/TRPLY assertion (1..15).
- SYNC_STAGES, 2, synchroniser flops on every asynchronous input (2..4).
- TIMEOUT, 255, clk20 cycles TRPLY may stay asserted before forced release (used only with the optional feature).

Ports:
- clk20  in  1  20 MHz QBUS domain clock.
- reset_L  in  1  asynchronous, active-low reset.
- RSYNC  in  1  bus SYNC; address phase qualifier.
- RDIN  in  1  bus DIN; asynchronous.
- RDOUT  in  1  bus DOUT; asynchronous.
- match  in  NCHAN  per-channel address match from the device address latches; asynchronous.
- vec_req  in  NCHAN  per-channel "assert vector" from interrupt logic; asynchronous.
- rdata  in  16*NCHAN  per-channel read data, channel i at [16i+15:16i].
- TRPLY  out  1  bus reply.
- DALtx  out  1  Am2908 direction, 1 = drive.
- DALbe  out  1  Am2908 bus enable, active high; the top level inverts it to DALbe_L.
- DALst  out  1  Am2908 output latch strobe.
- TDAL  out  22  transmit data; [21:16] always 0.
- sel  out  NCHAN  one-hot channel owning the current cycle; 0 when idle.
- wr_strobe  out  1  one-clock pulse when DATO data is valid for sel.
- rd_done  out  1  one-clock pulse when a DATI or vector read completes.
- tmo_err  out  1  sticky timeout flag, cleared by reset (optional feature only).

Behaviour:
- Reset (reset_L low, asynchronous): all outputs 0, state IDLE, synchronisers cleared.
- Synchronised signals: sRDIN, sRDOUT, smatch[i], svec[i], each SYNC_STAGES flops deep. smatch is additionally gated by RSYNC, which is itself synchronised.
- Arbitration in IDLE: pick the lowest index i with smatch[i] (if any), otherwise with svec[i]. Latch i into sel; sel holds until return to IDLE even if match drops.
- TDAL = {6'b0, rdata[sel]} whenever sel is nonzero, otherwise 0; combinational from latched sel.
- States:
  - IDLE: on smatch & sRDIN go to RD_SET. On smatch & sRDOUT go to WR_ACK. On svec & sRDIN go to RD_SET; RSYNC is low for vector reads. If sRDIN and sRDOUT are both high, RDIN wins.
  - RD_SET: DALtx=1, counter loads SETTLE-1 and decrements. At 0, go to RD_ACK.
  - RD_ACK: DALtx=DALbe=DALst=TRPLY=1. When sRDIN=0, pulse rd_done and go to REL.
  - WR_ACK: TRPLY=1. wr_strobe pulses on the first cycle only. When sRDOUT=0, go to REL.
  - REL: all bus outputs 0. Wait until sRDIN=0 and sRDOUT=0 and RSYNC (synchronised) is 0 or the match is gone, then go to IDLE and clear sel.
- Latency: TRPLY asserts SYNC_STAGES+1+SETTLE clocks after RDIN rises for reads, and SYNC_STAGES+1 clocks after RDOUT rises for writes.
- Back-to-back DATIO (DIN then DOUT under one SYNC): REL returns to IDLE once DIN is low. A new sRDOUT while match is still present then starts WR_ACK on the same channel.
- A match or vec_req arriving while busy is ignored until IDLE.
- sel with NCHAN=1 is a 1-bit flag.

Optional Feature:
- Macro QSLAVE_TIMEOUT_EN.
- When defined: a 16-bit counter runs while TRPLY=1. On reaching TIMEOUT, force REL, set tmo_err=1 (sticky), and suppress rd_done.
- When undefined: no counter; tmo_err is tied 0; a hung master holds TRPLY indefinitely.

Test Plan:
- Reset mid-RD_ACK (reset_L low while TRPLY=1) -> TRPLY/DALtx/DALbe/DALst/sel all 0 within the same cycle; after reset_L high, IDLE.
- DATI on ch1, rdata ch1=16'o123456, SETTLE=2, SYNC_STAGES=2 -> DALtx at RDIN+3 clocks, TRPLY/DALst at RDIN+5, TDAL=22'o0123456, rd_done one pulse after RDIN falls.
- match=4'b0110 with RDOUT -> sel=4'b0010, wr_strobe exactly one pulse, TRPLY until RDOUT falls, then sel=0.
- vec_req[3] with RSYNC low, RDIN high, rdata ch3=16'o000220 -> TDAL=22'o220, TRPLY asserted, sel=4'b1000.
- DATIO on ch0: DIN cycle then DOUT cycle under one RSYNC -> two replies; rd_done then wr_strobe; sel stays 4'b0001 throughout.
- QSLAVE_TIMEOUT_EN, TIMEOUT=10, RDIN held high -> TRPLY drops 10 clocks after assertion, tmo_err=1, no rd_done.

Source files
------------

// File: rtl/qslave_seq.sv
`timescale 1ns/1ps
// qslave_seq: QBUS slave-cycle sequencer for NCHAN register devices that
// share one Am2908 transceiver bank.
//
// All asynchronous bus and device inputs are synchronised into clk20. A
// fixed-priority arbiter (channel 0 highest) picks the device that owns the
// cycle. The sequencer then drives TRPLY and the Am2908 controls, muxes the
// owning device's read data onto TDAL and issues write/read completion
// pulses.
//
// Optional feature: define QSLAVE_TIMEOUT_EN to force release of a TRPLY
// that has been held for TIMEOUT clocks and to raise the sticky tmo_err.
//
// Ports
//   clk20      in   QBUS domain clock (20 MHz)
//   reset_L    in   asynchronous active-low reset
//   RSYNC      in   bus SYNC (address phase qualifier)
//   RDIN       in   bus DIN, asynchronous
//   RDOUT      in   bus DOUT, asynchronous
//   match      in   per-channel address match, asynchronous
//   vec_req    in   per-channel interrupt vector request, asynchronous
//   rdata      in   per-channel read data, channel i at [16i+15:16i]
//   TRPLY      out  bus reply
//   DALtx      out  Am2908 direction, 1 = drive bus
//   DALbe      out  Am2908 bus enable (active high)
//   DALst      out  Am2908 output latch strobe
//   TDAL       out  transmit data, [21:16] always 0
//   sel        out  one-hot owning channel, 0 when idle
//   wr_strobe  out  one-clock pulse, DATO data valid for sel
//   rd_done    out  one-clock pulse, DATI or vector read complete
//   tmo_err    out  sticky reply timeout flag (0 without the feature)
module qslave_seq #(
    parameter int unsigned NCHAN       = 4,
    parameter int unsigned SETTLE      = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                 clk20,
    input  logic                 reset_L,
    input  logic                 RSYNC,
    input  logic                 RDIN,
    input  logic                 RDOUT,
    input  logic [NCHAN-1:0]     match,
    input  logic [NCHAN-1:0]     vec_req,
    input  logic [16*NCHAN-1:0]  rdata,
    output logic                 TRPLY,
    output logic                 DALtx,
    output logic                 DALbe,
    output logic                 DALst,
    output logic [21:0]          TDAL,
    output logic [NCHAN-1:0]     sel,
    output logic                 wr_strobe,
    output logic                 rd_done,
    output logic                 tmo_err
);

    localparam int unsigned SW = 3 + 2 * NCHAN;

    typedef enum logic [2:0] {
        StIdle,
        StRdSet,
        StRdAck,
        StWrAck,
        StRel
    } state_e;

    // ------------------------------------------------------------------
    // Synchronisers: one shift chain carrying every asynchronous input.
    // ------------------------------------------------------------------
    logic [SW-1:0] r_sync [SYNC_STAGES];

    always_ff @(posedge clk20 or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= {RSYNC, RDIN, RDOUT, match, vec_req};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    logic [SW-1:0]    w_sync;
    logic             w_srsync;
    logic             w_srdin;
    logic             w_srdout;
    logic [NCHAN-1:0] w_smatch;
    logic [NCHAN-1:0] w_svec;
    logic [NCHAN-1:0] w_match_pick;
    logic [NCHAN-1:0] w_vec_pick;

    assign w_sync   = r_sync[SYNC_STAGES-1];
    assign w_srsync = w_sync[SW-1];
    assign w_srdin  = w_sync[SW-2];
    assign w_srdout = w_sync[SW-3];
    // A match only counts while the address phase is qualified by SYNC.
    assign w_smatch = w_sync[2*NCHAN-1:NCHAN] & {NCHAN{w_srsync}};
    assign w_svec   = w_sync[NCHAN-1:0];

    // Isolate the lowest set bit: lowest index wins.
    assign w_match_pick = w_smatch & (~w_smatch + NCHAN'(1));
    assign w_vec_pick   = w_svec & (~w_svec + NCHAN'(1));

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    state_e           r_state, w_state_d;
    logic [3:0]       r_cnt, w_cnt_d;
    logic [NCHAN-1:0] r_sel, w_sel_d;
    logic             r_rd_cycle, w_rd_cycle_d;
    logic             r_wr_first;
    logic             w_tmo;

    always_ff @(posedge clk20 or negedge reset_L) begin
        if (!reset_L) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_sel      <= '0;
            r_rd_cycle <= 1'b0;
            r_wr_first <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_cnt      <= w_cnt_d;
            r_sel      <= w_sel_d;
            r_rd_cycle <= w_rd_cycle_d;
            r_wr_first <= (r_state == StIdle) && (w_state_d == StWrAck);
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt;
        w_sel_d      = r_sel;
        w_rd_cycle_d = r_rd_cycle;
        TRPLY        = 1'b0;
        DALtx        = 1'b0;
        DALbe        = 1'b0;
        DALst        = 1'b0;
        wr_strobe    = 1'b0;
        rd_done      = 1'b0;

        case (r_state)
            StIdle: begin
                // Address matches take precedence over vector requests; DIN
                // takes precedence over DOUT.
                if (|w_smatch) begin
                    if (w_srdin) begin
                        w_state_d    = StRdSet;
                        w_sel_d      = w_match_pick;
                        w_cnt_d      = 4'(SETTLE - 1);
                        w_rd_cycle_d = 1'b1;
                    end else if (w_srdout) begin
                        w_state_d    = StWrAck;
                        w_sel_d      = w_match_pick;
                        w_rd_cycle_d = 1'b0;
                    end
                end else if ((|w_svec) && w_srdin) begin
                    w_state_d    = StRdSet;
                    w_sel_d      = w_vec_pick;
                    w_cnt_d      = 4'(SETTLE - 1);
                    w_rd_cycle_d = 1'b1;
                end
            end

            StRdSet: begin
                DALtx = 1'b1;
                if (r_cnt == 4'd0) begin
                    w_state_d = StRdAck;
                end else begin
                    w_cnt_d = r_cnt - 4'd1;
                end
            end

            StRdAck: begin
                DALtx = 1'b1;
                DALbe = 1'b1;
                DALst = 1'b1;
                TRPLY = 1'b1;
                if (w_tmo) begin
                    w_state_d = StRel;
                end else if (!w_srdin) begin
                    rd_done   = 1'b1;
                    w_state_d = StRel;
                end
            end

            StWrAck: begin
                TRPLY     = 1'b1;
                wr_strobe = r_wr_first;
                if (w_tmo || !w_srdout) begin
                    w_state_d = StRel;
                end
            end

            StRel: begin
                // After a read, leave as soon as the strobes are gone so a
                // DOUT can follow under the same SYNC (DATIO). After a write,
                // also wait for the address phase to end so the same cycle is
                // not re-entered.
                if (!w_srdin && !w_srdout &&
                    (r_rd_cycle || !(|(w_smatch & r_sel)))) begin
                    w_state_d = StIdle;
                    w_sel_d   = '0;
                end
            end

            default: begin
                w_state_d = StIdle;
                w_sel_d   = '0;
            end
        endcase
    end

    assign sel = r_sel;

    // ------------------------------------------------------------------
    // Read data mux from the latched owner.
    // ------------------------------------------------------------------
    logic [15:0] w_rd_mux;

    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < NCHAN; i++) begin
            w_rd_mux = w_rd_mux | (rdata[16*i +: 16] & {16{r_sel[i]}});
        end
    end

    assign TDAL = {6'b0, w_rd_mux};

    // ------------------------------------------------------------------
    // Reply timeout
    // ------------------------------------------------------------------
`ifdef QSLAVE_TIMEOUT_EN
    logic [15:0] r_tmo_cnt;
    logic        r_tmo_err;

    // Counts clocks of asserted TRPLY; the limit fires on the last allowed
    // cycle so TRPLY is gone exactly TIMEOUT clocks after it rose.
    assign w_tmo = (r_tmo_cnt == 16'(TIMEOUT - 1));

    always_ff @(posedge clk20 or negedge reset_L) begin
        if (!reset_L) begin
            r_tmo_cnt <= '0;
            r_tmo_err <= 1'b0;
        end else begin
            r_tmo_cnt <= TRPLY ? r_tmo_cnt + 16'd1 : 16'd0;
            if (TRPLY && w_tmo) begin
                r_tmo_err <= 1'b1;
            end
        end
    end

    assign tmo_err = r_tmo_err;
`else
    logic w_unused_timeout;

    assign w_tmo            = 1'b0;
    assign tmo_err          = 1'b0;
    assign w_unused_timeout = |32'(TIMEOUT);
`endif

endmodule

// File: tb/tb_qslave_seq.sv
`timescale 1ns/1ps
module tb_qslave_seq;

    localparam int NCHAN = 4;

    localparam int KDaltx  = 0;
    localparam int KTrplyR = 1;
    localparam int KWr     = 2;
    localparam int KRd     = 3;
    localparam int KTrplyF = 4;
    localparam int KProbe  = 5;

    logic              clk20   = 1'b0;
    logic              reset_L = 1'b0;
    logic              RSYNC   = 1'b0;
    logic              RDIN    = 1'b0;
    logic              RDOUT   = 1'b0;
    logic [NCHAN-1:0]  match   = '0;
    logic [NCHAN-1:0]  vec_req = '0;
    logic [16*NCHAN-1:0] rdata;
    logic              TRPLY, DALtx, DALbe, DALst;
    logic [21:0]       TDAL;
    logic [NCHAN-1:0]  sel;
    logic              wr_strobe, rd_done, tmo_err;

    qslave_seq #(
        .NCHAN       (NCHAN),
        .SETTLE      (2),
        .SYNC_STAGES (2),
        .TIMEOUT     (10)
    ) dut (
        .clk20     (clk20),
        .reset_L   (reset_L),
        .RSYNC     (RSYNC),
        .RDIN      (RDIN),
        .RDOUT     (RDOUT),
        .match     (match),
        .vec_req   (vec_req),
        .rdata     (rdata),
        .TRPLY     (TRPLY),
        .DALtx     (DALtx),
        .DALbe     (DALbe),
        .DALst     (DALst),
        .TDAL      (TDAL),
        .sel       (sel),
        .wr_strobe (wr_strobe),
        .rd_done   (rd_done),
        .tmo_err   (tmo_err)
    );

    always #25 clk20 = ~clk20;

    int cyc = 0;
    always @(posedge clk20) cyc <= cyc + 1;

    typedef struct {
        int          kind;
        int          cyc;     // -1: any cycle
        logic [3:0]  sel;
        logic [21:0] tdal;
        logic [4:0]  flags;   // {tmo_err, TRPLY, DALtx, DALbe, DALst}
    } ev_t;

    ev_t exp_q[$];
    int  checks     = 0;
    int  failures   = 0;
    int  probe_req  = 0;
    int  probe_seen = 0;

    function automatic string kname(input int k);
        case (k)
            KDaltx:  return "daltx_rise";
            KTrplyR: return "trply_rise";
            KWr:     return "wr_strobe";
            KRd:     return "rd_done";
            KTrplyF: return "trply_fall";
            default: return "probe";
        endcase
    endfunction

    task automatic expect_ev(input int k, input int at, input logic [3:0] s,
                             input logic [21:0] t, input logic [4:0] f);
        ev_t e;
        e.kind  = k;
        e.cyc   = at;
        e.sel   = s;
        e.tdal  = t;
        e.flags = f;
        exp_q.push_back(e);
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic observe(input int k);
        ev_t         e;
        logic [4:0]  f;
        f = {tmo_err, TRPLY, DALtx, DALbe, DALst};
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_%s: got cyc=%0d sel=%b tdal=%o flags=%b, required none",
                     kname(k), cyc, sel, TDAL, f);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || (e.cyc >= 0 && e.cyc != cyc) || e.sel != sel ||
                e.tdal != TDAL || e.flags != f) begin
                failures++;
                $display("FAIL %s: got %s cyc=%0d sel=%b tdal=%o flags=%b, required %s cyc=%0d sel=%b tdal=%o flags=%b",
                         kname(e.kind), kname(k), cyc, sel, TDAL, f,
                         kname(e.kind), e.cyc, e.sel, e.tdal, e.flags);
            end
        end
    endtask

    logic p_daltx = 1'b0;
    logic p_trply = 1'b0;

    always @(negedge clk20) begin
        if (DALtx && !p_daltx) observe(KDaltx);
        if (TRPLY && !p_trply) observe(KTrplyR);
        if (wr_strobe)         observe(KWr);
        if (rd_done)           observe(KRd);
        if (!TRPLY && p_trply) observe(KTrplyF);
        if (probe_req != probe_seen) begin
            probe_seen = probe_req;
            observe(KProbe);
        end
        p_daltx = DALtx;
        p_trply = TRPLY;
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk20);
            #1;
        end
    endtask

    task automatic probe(input logic [3:0] s, input logic [21:0] t, input logic [4:0] f);
        expect_ev(KProbe, -1, s, t, f);
        probe_req++;
    endtask

    // DATI / vector read: DALtx at +3, TRPLY at +5, rd_done 2 clocks after
    // DIN falls, TRPLY gone one clock later.
    task automatic dati(input logic [3:0] s, input logic [21:0] t);
        int c;
        RDIN = 1'b1;
        c = cyc;
        expect_ev(KDaltx,  c + 3, s, t, 5'b00100);
        expect_ev(KTrplyR, c + 5, s, t, 5'b01111);
        step(8);
        RDIN = 1'b0;
        c = cyc;
        expect_ev(KRd,     c + 2, s, t, 5'b01111);
        expect_ev(KTrplyF, c + 3, s, t, 5'b00000);
        step(5);
    endtask

    // DATO: TRPLY and a single wr_strobe at +3; while SYNC and match stay up
    // the owner stays selected with outputs released.
    task automatic dato(input logic [3:0] s, input logic [21:0] t);
        int c;
        RDOUT = 1'b1;
        c = cyc;
        expect_ev(KTrplyR, c + 3, s, t, 5'b01000);
        expect_ev(KWr,     c + 3, s, t, 5'b01000);
        step(4);
        RDOUT = 1'b0;
        c = cyc;
        expect_ev(KTrplyF, c + 3, s, t, 5'b00000);
        step(6);
        probe(s, t, 5'b00000);
        step(1);
    endtask

    initial begin
        rdata = {16'o000220, 16'o055555, 16'o123456, 16'o007070};

        // Reset state.
        step(2);
        probe(4'b0000, 22'o0, 5'b00000);
        step(1);
        reset_L = 1'b1;
        step(3);
        probe(4'b0000, 22'o0, 5'b00000);
        step(2);

        // DATI on channel 1.
        RSYNC = 1'b1;
        match = 4'b0010;
        step(3);
        dati(4'b0010, 22'o123456);
        RSYNC = 1'b0;
        match = 4'b0000;
        step(1);
        probe(4'b0000, 22'o0, 5'b00000);
        step(3);

        // DATO with two matching channels: lowest index owns it.
        RSYNC = 1'b1;
        match = 4'b0110;
        step(3);
        dato(4'b0010, 22'o123456);
        RSYNC = 1'b0;
        match = 4'b0000;
        step(5);
        probe(4'b0000, 22'o0, 5'b00000);
        step(2);

        // Vector read on channel 3, RSYNC low.
        vec_req = 4'b1000;
        step(3);
        dati(4'b1000, 22'o220);
        vec_req = 4'b0000;
        step(1);
        probe(4'b0000, 22'o0, 5'b00000);
        step(3);

        // Two vector requests: channel 1 wins.
        vec_req = 4'b1010;
        step(3);
        dati(4'b0010, 22'o123456);
        vec_req = 4'b0000;
        step(4);

        // DATIO on channel 0 under one SYNC.
        RSYNC = 1'b1;
        match = 4'b0011;
        step(3);
        dati(4'b0001, 22'o007070);
        dato(4'b0001, 22'o007070);
        RSYNC = 1'b0;
        match = 4'b0000;
        step(5);
        probe(4'b0000, 22'o0, 5'b00000);
        step(2);

        // Reset while replying: everything drops in the same cycle.
        RSYNC = 1'b1;
        match = 4'b0100;
        step(3);
        RDIN = 1'b1;
        begin
            int c;
            c = cyc;
            expect_ev(KDaltx,  c + 3, 4'b0100, 22'o055555, 5'b00100);
            expect_ev(KTrplyR, c + 5, 4'b0100, 22'o055555, 5'b01111);
        end
        step(7);
        reset_L = 1'b0;
        expect_ev(KTrplyF, cyc, 4'b0000, 22'o0, 5'b00000);
        probe(4'b0000, 22'o0, 5'b00000);
        step(1);
        RDIN  = 1'b0;
        RSYNC = 1'b0;
        match = 4'b0000;
        step(2);
        reset_L = 1'b1;
        step(5);
        probe(4'b0000, 22'o0, 5'b00000);
        step(2);

`ifdef QSLAVE_TIMEOUT_EN
        // Hung master: TRPLY released 10 clocks after it rose, no rd_done.
        RSYNC = 1'b1;
        match = 4'b0010;
        step(3);
        RDIN = 1'b1;
        begin
            int c;
            c = cyc;
            expect_ev(KDaltx,  c + 3,  4'b0010, 22'o123456, 5'b00100);
            expect_ev(KTrplyR, c + 5,  4'b0010, 22'o123456, 5'b01111);
            expect_ev(KTrplyF, c + 15, 4'b0010, 22'o123456, 5'b10000);
        end
        step(20);
        probe(4'b0010, 22'o123456, 5'b10000);
        step(1);
        RDIN  = 1'b0;
        RSYNC = 1'b0;
        match = 4'b0000;
        step(5);
        probe(4'b0000, 22'o0, 5'b10000);
        step(2);
`endif

        // Drain: anything still expected never showed up.
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) step(1);
        while (exp_q.size() != 0) begin
            ev_t e;
            e = exp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_%s: got no event, required cyc=%0d sel=%b tdal=%o flags=%b",
                     kname(e.kind), e.cyc, e.sel, e.tdal, e.flags);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
